lsu_ctrl: RTL and testbench

Load/store sequencer between execute and the writeback stage. Accepts one memory operation at a time from execute and issues a single row-aligned request to the 64-bit data memory. For loads, it captures the returned row and presents it with size, extension and row-index metadata to writeback, which extracts and extends the value. Stores complete on grant; misaligned accesses and memory timeouts are reported as single-cycle error pulses.

---
 rtl/cpu_consts.sv | 32 +++
 rtl/lsu_store_align.sv | 27 ++
 rtl/lsu_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_consts.sv
// Shared CPU pipeline types and constants; this slice carries the load/store unit definitions.
package cpu_consts;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_RD = 2'd2,
        WB      = 2'd3
    } lsu_state_t;

    localparam int LSU_CNT_W = 8;

    function automatic logic [7:0] size_base_mask(input mem_size_t size);
        logic [7:0] mask;
        case (size)
            SIZE_B:  mask = 8'h01;
            SIZE_H:  mask = 8'h03;
            SIZE_W:  mask = 8'h0F;
            SIZE_D:  mask = 8'hFF;
            default: mask = 8'h00;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lsu_store_align.sv
// Places store data and byte-lane mask within a 64-bit row and flags accesses
// that are not naturally aligned for their size.
module lsu_store_align
    import cpu_consts::*;
(
    input  mem_size_t   i_size,
    input  logic [2:0]  i_row_idx,
    input  logic [63:0] i_wr_data,
    output logic [7:0]  o_mask,
    output logic [63:0] o_data,
    output logic        o_misaligned
);

    // Lane placement and natural-alignment check
    always_comb begin
        o_mask = size_base_mask(i_size) << i_row_idx;
        o_data = i_wr_data << {i_row_idx, 3'b000};
        case (i_size)
            SIZE_B:  o_misaligned = 1'b0;
            SIZE_H:  o_misaligned = i_row_idx[0];
            SIZE_W:  o_misaligned = (i_row_idx[1:0] != 2'b00);
            SIZE_D:  o_misaligned = (i_row_idx != 3'b000);
            default: o_misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one operation at a time, one row-aligned memory request,
// load rows handed to writeback with size/extension/row metadata.
module lsu_ctrl
    import cpu_consts::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_is_store_i,
    input  logic [63:0] req_addr_i,
    input  logic [63:0] req_wr_data_i,
    input  logic [1:0]  req_byte_en_i,
    input  logic        req_zero_extnd_i,
    input  logic [4:0]  req_rd_i,
    output logic        mem_req_o,
    output logic        mem_wr_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wr_data_o,
    output logic [7:0]  mem_wr_mask_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [63:0] mem_rdata_i,
    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic [4:0]  wb_rd_o,
    output logic [63:0] wb_data_mem_rd_o,
    output logic [1:0]  wb_byte_en_o,
    output logic        wb_zero_extnd_o,
    output logic [2:0]  wb_row_idx_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        busy_o
);

    localparam logic [LSU_CNT_W-1:0] TO_LAST = LSU_CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t           r_state;
    lsu_state_t           w_state_nxt;
    logic [LSU_CNT_W-1:0] r_cnt;
    logic                 r_is_store;
    logic                 r_zext;
    logic                 r_misalign;
    logic                 r_bus_err;
    logic [60:0]          r_row_addr;
    logic [63:0]          r_wr_data;
    logic [7:0]           r_wr_mask;
    logic [63:0]          r_rdata;
    logic [4:0]           r_rd;
    mem_size_t            r_size;
    logic [2:0]           r_row_idx;

    logic                 w_accept;
    logic                 w_misalign_nxt;
    logic                 w_bus_err_nxt;
    logic                 w_timeout;
    logic                 w_in_req;
    logic [7:0]           w_al_mask;
    logic [63:0]          w_al_data;
    logic                 w_al_mis;

    lsu_store_align u_align (
        .i_size       (mem_size_t'(req_byte_en_i)),
        .i_row_idx    (req_addr_i[2:0]),
        .i_wr_data    (req_wr_data_i),
        .o_mask       (w_al_mask),
        .o_data       (w_al_data),
        .o_misaligned (w_al_mis)
    );

    assign w_timeout = (r_cnt == TO_LAST);
    assign w_in_req  = (r_state == REQ);

    // Next-state decode; the exit event always takes priority over the timeout
    always_comb begin
        w_state_nxt    = r_state;
        w_accept       = 1'b0;
        w_misalign_nxt = 1'b0;
        w_bus_err_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid_i && w_al_mis) begin
                    w_misalign_nxt = 1'b1;
                end else if (req_valid_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = REQ;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    w_state_nxt = r_is_store ? IDLE : WAIT_RD;
                end else if (w_timeout) begin
                    w_bus_err_nxt = 1'b1;
                    w_state_nxt   = IDLE;
                end else begin
                    w_state_nxt = REQ;
                end
            end
            WAIT_RD: begin
                if (mem_rvalid_i) begin
                    w_state_nxt = WB;
                end else if (w_timeout) begin
                    w_bus_err_nxt = 1'b1;
                    w_state_nxt   = IDLE;
                end else begin
                    w_state_nxt = WAIT_RD;
                end
            end
            WB: begin
                if (wb_ready_i) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = WB;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Wait counter restarts on every state change, so it is zero on entry to REQ and WAIT_RD
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= '0;
        end else if (r_state == REQ || r_state == WAIT_RD) begin
            r_cnt <= r_cnt + 8'd1;
        end else begin
            r_cnt <= '0;
        end
    end

    // Single-cycle error pulses
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_misalign <= w_misalign_nxt;
            r_bus_err  <= w_bus_err_nxt;
        end
    end

    // Request capture; load requests carry no write data or mask
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_is_store <= 1'b0;
            r_row_addr <= '0;
            r_wr_data  <= 64'd0;
            r_wr_mask  <= 8'h00;
            r_rd       <= 5'd0;
            r_size     <= SIZE_B;
            r_zext     <= 1'b0;
            r_row_idx  <= 3'd0;
        end else if (w_accept) begin
            r_is_store <= req_is_store_i;
            r_row_addr <= req_addr_i[63:3];
            r_wr_data  <= req_is_store_i ? w_al_data : 64'd0;
            r_wr_mask  <= req_is_store_i ? w_al_mask : 8'h00;
            r_rd       <= req_rd_i;
            r_size     <= mem_size_t'(req_byte_en_i);
            r_zext     <= req_zero_extnd_i;
            r_row_idx  <= req_addr_i[2:0];
        end else begin
            r_is_store <= r_is_store;
        end
    end

    // Read row capture, only while a read is outstanding
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdata <= 64'd0;
        end else if (r_state == WAIT_RD && mem_rvalid_i) begin
            r_rdata <= mem_rdata_i;
        end else begin
            r_rdata <= r_rdata;
        end
    end

    assign req_ready_o      = (r_state == IDLE);
    assign busy_o           = (r_state != IDLE);
    assign mem_req_o        = w_in_req;
    assign mem_wr_o         = w_in_req & r_is_store;
    assign mem_addr_o       = w_in_req ? {r_row_addr, 3'b000} : 64'd0;
    assign mem_wr_data_o    = w_in_req ? r_wr_data : 64'd0;
    assign mem_wr_mask_o    = w_in_req ? r_wr_mask : 8'h00;
    assign wb_valid_o       = (r_state == WB);
    assign wb_rd_o          = r_rd;
    assign wb_data_mem_rd_o = r_rdata;
    assign wb_byte_en_o     = r_size;
    assign wb_zero_extnd_o  = r_zext;
    assign wb_row_idx_o     = r_row_idx;
    assign misalign_o       = r_misalign;
    assign bus_err_o        = r_bus_err;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed vector table, an async-reset sequence and random
// operations checked against a transaction-level model.
module tb_lsu_ctrl;

    localparam int TO = 4;

    typedef struct {
        logic        st;
        logic [63:0] addr;
        logic [63:0] wd;
        logic [1:0]  size;
        logic        zext;
        logic [4:0]  rd;
        int          gnt_dly;
        int          rv_dly;
        logic [63:0] rdata;
        int          wbr_dly;
    } op_t;

    typedef struct {
        logic        mis;
        logic [7:0]  mask;
        logic [63:0] wd;
        logic        err;
    } exp_t;

    typedef struct {
        op_t  op;
        exp_t e;
    } vec_t;

    logic        clk;
    logic        resetn;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_is_store_i;
    logic [63:0] req_addr_i;
    logic [63:0] req_wr_data_i;
    logic [1:0]  req_byte_en_i;
    logic        req_zero_extnd_i;
    logic [4:0]  req_rd_i;
    logic        mem_req_o;
    logic        mem_wr_o;
    logic [63:0] mem_addr_o;
    logic [63:0] mem_wr_data_o;
    logic [7:0]  mem_wr_mask_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [63:0] mem_rdata_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [4:0]  wb_rd_o;
    logic [63:0] wb_data_mem_rd_o;
    logic [1:0]  wb_byte_en_o;
    logic        wb_zero_extnd_o;
    logic [2:0]  wb_row_idx_o;
    logic        misalign_o;
    logic        bus_err_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    vec_t vecs[10];
    op_t  rop;

    lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_is_store_i   (req_is_store_i),
        .req_addr_i       (req_addr_i),
        .req_wr_data_i    (req_wr_data_i),
        .req_byte_en_i    (req_byte_en_i),
        .req_zero_extnd_i (req_zero_extnd_i),
        .req_rd_i         (req_rd_i),
        .mem_req_o        (mem_req_o),
        .mem_wr_o         (mem_wr_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wr_data_o    (mem_wr_data_o),
        .mem_wr_mask_o    (mem_wr_mask_o),
        .mem_gnt_i        (mem_gnt_i),
        .mem_rvalid_i     (mem_rvalid_i),
        .mem_rdata_i      (mem_rdata_i),
        .wb_valid_o       (wb_valid_o),
        .wb_ready_i       (wb_ready_i),
        .wb_rd_o          (wb_rd_o),
        .wb_data_mem_rd_o (wb_data_mem_rd_o),
        .wb_byte_en_o     (wb_byte_en_o),
        .wb_zero_extnd_o  (wb_zero_extnd_o),
        .wb_row_idx_o     (wb_row_idx_o),
        .misalign_o       (misalign_o),
        .bus_err_o        (bus_err_o),
        .busy_o           (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready_o), 64'd1);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_mem_req"}, 64'(mem_req_o), 64'd0);
        chk({tag, "_mem_wr"}, 64'(mem_wr_o), 64'd0);
        chk({tag, "_mem_addr"}, mem_addr_o, 64'd0);
        chk({tag, "_mem_wdata"}, mem_wr_data_o, 64'd0);
        chk({tag, "_mem_mask"}, 64'(mem_wr_mask_o), 64'd0);
        chk({tag, "_wb_valid"}, 64'(wb_valid_o), 64'd0);
        chk({tag, "_wb_rd"}, 64'(wb_rd_o), 64'd0);
        chk({tag, "_wb_data"}, wb_data_mem_rd_o, 64'd0);
        chk({tag, "_wb_size"}, 64'(wb_byte_en_o), 64'd0);
        chk({tag, "_wb_zext"}, 64'(wb_zero_extnd_o), 64'd0);
        chk({tag, "_wb_row"}, 64'(wb_row_idx_o), 64'd0);
        chk({tag, "_misalign"}, 64'(misalign_o), 64'd0);
        chk({tag, "_bus_err"}, 64'(bus_err_o), 64'd0);
    endtask

    // Transaction-level expectations from the access rules, in plain arithmetic
    function automatic exp_t model(input op_t t);
        exp_t e;
        int   nbytes;
        int   row;
        nbytes = 1 << t.size;
        row    = int'(t.addr[2:0]);
        e.mis  = (t.addr % 64'(nbytes)) != 64'd0;
        e.mask = t.st ? 8'(((1 << nbytes) - 1) << row) : 8'h00;
        e.wd   = t.st ? (t.wd << (8 * row)) : 64'd0;
        e.err  = !e.mis && (t.gnt_dly >= TO || (!t.st && t.rv_dly >= TO));
        return e;
    endfunction

    task automatic run_op(input op_t t, input exp_t e);
        int   n_err;
        logic done;
        n_err = 0;
        chk("ready_before_req", 64'(req_ready_o), 64'd1);
        req_valid_i      = 1'b1;
        req_is_store_i   = t.st;
        req_addr_i       = t.addr;
        req_wr_data_i    = t.wd;
        req_byte_en_i    = t.size;
        req_zero_extnd_i = t.zext;
        req_rd_i         = t.rd;
        step();
        req_valid_i   = 1'b0;
        req_addr_i    = {$urandom, $urandom};
        req_wr_data_i = {$urandom, $urandom};
        req_rd_i      = 5'($urandom);
        chk("misalign_pulse", 64'(misalign_o), 64'(e.mis));
        if (e.mis) begin
            chk("misalign_no_mem_req", 64'(mem_req_o), 64'd0);
            chk("misalign_ready", 64'(req_ready_o), 64'd1);
            step();
            chk("misalign_one_cycle", 64'(misalign_o), 64'd0);
            chk("misalign_still_idle", 64'(mem_req_o), 64'd0);
            return;
        end
        done = 1'b0;
        for (int k = 0; k < TO && !done; k++) begin
            chk("mem_req", 64'(mem_req_o), 64'd1);
            chk("mem_wr", 64'(mem_wr_o), 64'(t.st));
            chk("mem_addr", mem_addr_o, t.addr & ~64'h7);
            chk("mem_wr_mask", 64'(mem_wr_mask_o), 64'(e.mask));
            chk("mem_wr_data", mem_wr_data_o, e.wd);
            mem_gnt_i = (k == t.gnt_dly);
            done      = mem_gnt_i;
            step();
            mem_gnt_i = 1'b0;
            n_err += int'(bus_err_o);
        end
        if (done && !t.st) begin
            done = 1'b0;
            for (int k = 0; k < TO && !done; k++) begin
                chk("wait_no_req", 64'(mem_req_o), 64'd0);
                chk("wait_no_wb", 64'(wb_valid_o), 64'd0);
                chk("wait_busy", 64'(busy_o), 64'd1);
                mem_rvalid_i = (k == t.rv_dly);
                mem_rdata_i  = mem_rvalid_i ? t.rdata : {$urandom, $urandom};
                done         = mem_rvalid_i;
                step();
                mem_rvalid_i = 1'b0;
                n_err += int'(bus_err_o);
            end
            if (done) begin
                for (int w = 0; w <= t.wbr_dly; w++) begin
                    chk("wb_valid", 64'(wb_valid_o), 64'd1);
                    chk("wb_rd", 64'(wb_rd_o), 64'(t.rd));
                    chk("wb_data", wb_data_mem_rd_o, t.rdata);
                    chk("wb_size", 64'(wb_byte_en_o), 64'(t.size));
                    chk("wb_zext", 64'(wb_zero_extnd_o), 64'(t.zext));
                    chk("wb_row_idx", 64'(wb_row_idx_o), 64'(t.addr[2:0]));
                    chk("wb_not_ready", 64'(req_ready_o), 64'd0);
                    wb_ready_i = (w == t.wbr_dly);
                    step();
                    wb_ready_i = 1'b0;
                end
            end
        end
        chk("idle_after_op", 64'(req_ready_o), 64'd1);
        chk("no_wb_after_op", 64'(wb_valid_o), 64'd0);
        chk("mem_req_dropped", 64'(mem_req_o), 64'd0);
        chk("bus_err_pulse", 64'(bus_err_o), 64'(e.err));
        chk("bus_err_count", 64'(n_err), 64'(e.err));
        if (e.err) begin
            step();
            chk("bus_err_one_cycle", 64'(bus_err_o), 64'd0);
        end
    endtask

    initial begin
        req_valid_i      = 1'b0;
        req_is_store_i   = 1'b0;
        req_addr_i       = 64'd0;
        req_wr_data_i    = 64'd0;
        req_byte_en_i    = 2'd0;
        req_zero_extnd_i = 1'b0;
        req_rd_i         = 5'd0;
        mem_gnt_i        = 1'b0;
        mem_rvalid_i     = 1'b0;
        mem_rdata_i      = 64'd0;
        wb_ready_i       = 1'b0;
        resetn           = 1'b1;

        //            st    addr          wd                      size  zext  rd     gnt  rv   rdata                   wbr     mis   mask   wd                      err
        vecs[0] = '{'{1'b1, 64'h1000, 64'hDEADBEEF_CAFEF00D, 2'd3, 1'b0, 5'd0,  0,   0,   64'd0,                  0}, '{1'b0, 8'hFF, 64'hDEADBEEF_CAFEF00D, 1'b0}};
        vecs[1] = '{'{1'b1, 64'h2005, 64'h0000_0000_0000_00AB, 2'd0, 1'b0, 5'd0,  1,   0,   64'd0,                  0}, '{1'b0, 8'h20, 64'h0000_AB00_0000_0000, 1'b0}};
        vecs[2] = '{'{1'b0, 64'h3006, 64'd0,                  2'd1, 1'b1, 5'd5,  1,   1,   64'h1234_0000_0000_0000, 3}, '{1'b0, 8'h00, 64'd0,                  1'b0}};
        vecs[3] = '{'{1'b0, 64'h4002, 64'd0,                  2'd2, 1'b0, 5'd3,  0,   0,   64'd0,                  0}, '{1'b1, 8'h00, 64'd0,                  1'b0}};
        vecs[4] = '{'{1'b1, 64'h5004, 64'h0000_0000_1122_3344, 2'd2, 1'b0, 5'd0,  255, 0,   64'd0,                  0}, '{1'b0, 8'hF0, 64'h1122_3344_0000_0000, 1'b1}};
        vecs[5] = '{'{1'b1, 64'h6002, 64'h0000_0000_0000_BEEF, 2'd1, 1'b0, 5'd0,  3,   0,   64'd0,                  0}, '{1'b0, 8'h0C, 64'h0000_0000_BEEF_0000, 1'b0}};
        vecs[6] = '{'{1'b0, 64'h7000, 64'd0,                  2'd3, 1'b0, 5'd9,  0,   255, 64'd0,                  0}, '{1'b0, 8'h00, 64'd0,                  1'b1}};
        vecs[7] = '{'{1'b0, 64'h8007, 64'd0,                  2'd0, 1'b0, 5'd31, 2,   3,   64'h8000_0000_0000_0000, 0}, '{1'b0, 8'h00, 64'd0,                  1'b0}};
        vecs[8] = '{'{1'b1, 64'h9004, 64'h0123_4567_89AB_CDEF, 2'd3, 1'b0, 5'd0,  0,   0,   64'd0,                  0}, '{1'b1, 8'h00, 64'd0,                  1'b0}};
        vecs[9] = '{'{1'b1, 64'hA001, 64'h0000_0000_0000_5A5A, 2'd1, 1'b0, 5'd0,  0,   0,   64'd0,                  0}, '{1'b1, 8'h00, 64'd0,                  1'b0}};

        #2;
        resetn = 1'b0;
        step();
        step();
        chk_reset_outputs("reset");
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].e);
        end

        // Async reset while a read is outstanding; a late rvalid must be ignored
        req_valid_i    = 1'b1;
        req_is_store_i = 1'b0;
        req_addr_i     = 64'h100;
        req_byte_en_i  = 2'd3;
        req_rd_i       = 5'd7;
        step();
        req_valid_i = 1'b0;
        mem_gnt_i   = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        chk("wait_rd_busy", 64'(busy_o), 64'd1);
        chk("wait_rd_no_req", 64'(mem_req_o), 64'd0);
        #2;
        resetn = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(negedge clk);
        resetn       = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'hFEED_FACE_0000_1111;
        step();
        mem_rvalid_i = 1'b0;
        chk("late_rvalid_no_wb", 64'(wb_valid_o), 64'd0);
        chk("late_rvalid_idle", 64'(req_ready_o), 64'd1);
        step();
        chk("late_rvalid_no_wb2", 64'(wb_valid_o), 64'd0);
        chk("late_rvalid_data_clear", wb_data_mem_rd_o, 64'd0);

        for (int i = 0; i < 150; i++) begin
            rop.st      = 1'($urandom);
            rop.size    = 2'($urandom_range(3, 0));
            rop.addr    = {$urandom, $urandom};
            if ($urandom_range(3, 0) != 0) begin
                rop.addr = rop.addr & ~64'((1 << (1 << rop.size)) - 1);
            end
            rop.wd      = {$urandom, $urandom};
            rop.zext    = 1'($urandom);
            rop.rd      = 5'($urandom);
            rop.gnt_dly = int'($urandom_range(TO, 0));
            rop.rv_dly  = int'($urandom_range(TO, 0));
            rop.rdata   = {$urandom, $urandom};
            rop.wbr_dly = int'($urandom_range(2, 0));
            if ($urandom_range(1, 0) != 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = {$urandom, $urandom};
                step();
                mem_rvalid_i = 1'b0;
                chk("idle_ignores_rvalid", 64'(wb_valid_o), 64'd0);
            end
            run_op(rop, model(rop));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
